dma_ahb_wr: RTL and testbench
=============================

# dma_ahb_wr

AHB-Lite master write engine for the DMA channel datapath. It sits directly downstream of the channel data FIFO. It pops words from the FIFO and writes them to a destination address range as pipelined single (NONSEQ) AHB-Lite write transfers, and it reports completion or bus error to the channel controller.

## Interface
- DATA_WIDTH, 32, FIFO word and HWDATA width
- CNT_WIDTH, 16, width of the beat counter
- clk  in  1  system clock (HCLK)
- resetn  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse that launches a transfer; ignored while busy=1
- dst_addr  in  32  first destination byte address, sampled on start
- xfer_cnt  in  CNT_WIDTH  number of beats, sampled on start; 0 is legal
- dst_size  in  2  beat size (0=byte, 1=half, 2=word; 3 is treated as 2), sampled on start
- dst_incr  in  1  1: address += 1<<dst_size per beat; 0: fixed address; sampled on start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  one-cycle pulse on termination by HRESP=ERROR
- fifo_empty  in  1  FIFO has no data
- fifo_rdata  in  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0
- fifo_rd  out  1  pop strobe; combinational
- HADDR  out  32  address phase address, registered
- HTRANS  out  2  IDLE=00 or NONSEQ=10, registered
- HWRITE  out  1  constant 1
- HSIZE  out  3  {1'b0, latched size}
- HBURST  out  3  constant 000 (SINGLE)
- HPROT  out  4  constant 0011
- HWDATA  out  DATA_WIDTH  data phase write data, registered
- HREADY  in  1  transfer-complete / bus ready
- HRESP  in  1  0=OKAY, 1=ERROR

## Operation
- **States:** IDLE, RUN, ERR. busy = (state != IDLE).
- **IDLE + start:**
  - Latch addr, left = xfer_cnt, size, incr.
  - If xfer_cnt = 0, go to RUN and finish immediately (done pulse, no bus transfer). Otherwise go to RUN.
- **Issue decision (RUN), evaluated each cycle:** issue = (left != 0) & ~fifo_empty.
- **Address-phase registers** (HADDR, HTRANS, pend_data) update only on edges where HREADY=1. The error cancel below is the only exception.
  - On such an edge with issue=1: HTRANS <= NONSEQ, HADDR <= addr, pend_data <= fifo_rdata, addr += incr ? (1<<size) : 0, left -= 1.
  - On such an edge with issue=0: HTRANS <= IDLE.
- **FIFO pop:** fifo_rd = (state==RUN) & issue & HREADY. The FIFO is popped exactly once per issued beat and never when fifo_empty=1.
- **Data phase:** on an edge with HREADY=1 and HTRANS=NONSEQ, set HWDATA <= pend_data and dphase <= 1. Otherwise, on HREADY=1, dphase <= 0. HWDATA holds during wait states.
- **Completion:** in RUN, when left = 0, HTRANS = IDLE, and (dphase = 0 or HREADY = 1 with HRESP = 0): done <= 1 and state <= IDLE.
- **Error:**
  - HRESP=1 with HREADY=0 in a data phase (first error cycle): HTRANS <= IDLE immediately (allowed cancel) and state <= ERR. The address beat cancelled this way is discarded, including its popped word.
  - In ERR, nothing is issued. On the HREADY=1 that ends the error response: error <= 1, state <= IDLE.
  - Unpopped FIFO words remain in the FIFO; the controller flushes them.
- **Address arithmetic:** addr is 32 bits and wraps modulo 2^32. Address alignment is the caller's duty; addr is driven as-is.
- **FIFO stall:** fifo_empty mid-transfer inserts IDLE cycles. The engine resumes the cycle after data appears, with no beat lost or duplicated.
- **Reset (also asynchronously, mid-transfer):** state IDLE, HTRANS=00, HADDR=0, HWDATA=0, pend_data=0, dphase=0, busy=0, done=0, error=0, fifo_rd=0. An in-flight bus transfer is abandoned.

## Timing
- Start pulse at edge t:
  - busy=1 from t+1.
  - First NONSEQ is visible in cycle t+2 if the FIFO is non-empty in cycle t+1.
- Zero-wait throughput: 1 beat per cycle, back-to-back NONSEQ.
- Data phase follows its address phase by exactly one accepted HREADY edge.
- done/error are high one cycle, coincident with busy falling. A start in that same cycle is accepted.
- fifo_rd is asserted in the cycle before the corresponding NONSEQ becomes visible.

## Test plan
- **Basic 4-beat write:** FIFO preloaded with 4 words A0..A3, dst_addr=0x2000_0000, size=2, incr=1, HREADY=1.
  - NONSEQ at 0x2000_0000/04/08/0C in cycles t+2..t+5.
  - HWDATA=A0..A3 in t+3..t+6.
  - done in t+7; 4 pops.
- **Wait states:** 2 beats, slave inserts 2 HREADY=0 cycles on beat 0.
  - HADDR/HTRANS/HWDATA hold stable through the wait.
  - Beat 1 address is held until HREADY=1.
  - done one cycle after the final HREADY=1.
- **FIFO starvation:** 3 beats, size=0, incr=0; FIFO supplies one word every 3 cycles.
  - Addresses all equal dst_addr, with IDLE gaps between beats.
  - Exactly 3 pops, data in order.
- **Error:** 8 beats; slave answers beat 2 with ERROR (HREADY=0/HRESP=1, then HREADY=1/HRESP=1).
  - HTRANS=IDLE in the first error cycle.
  - error pulse after the second error cycle; done never asserts.
  - busy falls; 4 pops total.
- **Zero count and wrap:**
  - xfer_cnt=0: done in t+2, no NONSEQ, no pop.
  - dst_addr=0xFFFF_FFFC, 2 words: addresses 0xFFFF_FFFC then 0x0000_0000.
- **Reset mid-transfer:** assert resetn=0 during beat 1 of 4. All outputs go to reset values immediately; a following start runs cleanly.

Source files
------------

// File: rtl/dma_ahb_wr_if.sv
// AHB-Lite bus bundle for the DMA write engine.
// The master drives the address/data phase signals; the slave returns HREADY/HRESP.
interface dma_ahb_wr_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HREADY, HRESP
    );
endinterface

// File: rtl/dma_ahb_wr.sv
// DMA channel AHB-Lite write engine.
// Pops words from the channel FIFO and writes them as pipelined SINGLE/NONSEQ
// transfers, then pulses done on success or error on an ERROR response.
module dma_ahb_wr #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [31:0]           dst_addr,
    input  logic [CNT_WIDTH-1:0]  xfer_cnt,
    input  logic [1:0]            dst_size,
    input  logic                  dst_incr,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd,
    dma_ahb_wr_if.master          ahb
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR
    } state_t;

    state_t                state;
    state_t                next_state;

    logic [31:0]           addr;
    logic [CNT_WIDTH-1:0]  left;
    logic [1:0]            size;
    logic                  incr;
    logic [31:0]           step;

    logic                  nonseq;
    logic [31:0]           haddr_q;
    logic [DATA_WIDTH-1:0] pend_data;
    logic [DATA_WIDTH-1:0] hwdata_q;
    logic                  dphase;

    logic                  launch;
    logic                  issue;
    logic                  cancel;
    logic                  done_set;
    logic                  error_set;

    // Fixed bus attributes plus the registered address/data phase outputs.
    assign ahb.HWRITE = 1'b1;
    assign ahb.HBURST = 3'b000;
    assign ahb.HPROT  = 4'b0011;
    assign ahb.HSIZE  = {1'b0, size};
    assign ahb.HTRANS = nonseq ? 2'b10 : 2'b00;
    assign ahb.HADDR  = haddr_q;
    assign ahb.HWDATA = hwdata_q;

    assign busy    = (state != IDLE);
    assign fifo_rd = issue & ahb.HREADY;
    assign step    = incr ? (32'd1 << size) : 32'd0;

    // State register; reset abandons any in-flight transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic together with the issue, cancel and completion decisions.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        issue      = 1'b0;
        cancel     = 1'b0;
        done_set   = 1'b0;
        error_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    launch     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                issue = (left != '0) & ~fifo_empty;
                if (dphase && !ahb.HREADY && ahb.HRESP) begin
                    cancel     = 1'b1;
                    next_state = ERR;
                end else if ((left == '0) && !nonseq &&
                             (!dphase || (ahb.HREADY && !ahb.HRESP))) begin
                    done_set   = 1'b1;
                    next_state = IDLE;
                end
            end
            ERR: begin
                if (ahb.HREADY) begin
                    error_set  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One-cycle completion pulses, registered so they coincide with busy falling.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done  <= done_set;
            error <= error_set;
        end
    end

    // Transfer parameters latched on start; size 3 behaves as a word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            size <= 2'd0;
            incr <= 1'b0;
        end else if (launch) begin
            size <= (dst_size == 2'd3) ? 2'd2 : dst_size;
            incr <= dst_incr;
        end
    end

    // Address phase: advances only on accepted edges, except for the error cancel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr      <= 32'd0;
            left      <= '0;
            nonseq    <= 1'b0;
            haddr_q   <= 32'd0;
            pend_data <= '0;
        end else if (launch) begin
            addr   <= dst_addr;
            left   <= xfer_cnt;
            if (ahb.HREADY) begin
                nonseq <= 1'b0;
            end
        end else if (cancel) begin
            nonseq <= 1'b0;
        end else if (ahb.HREADY) begin
            if (issue) begin
                nonseq    <= 1'b1;
                haddr_q   <= addr;
                pend_data <= fifo_rdata;
                addr      <= addr + step;
                left      <= left - CNT_WIDTH'(1);
            end else begin
                nonseq <= 1'b0;
            end
        end
    end

    // Data phase: the word captured with an address moves to HWDATA when that address is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hwdata_q <= '0;
            dphase   <= 1'b0;
        end else if (ahb.HREADY) begin
            if (nonseq) begin
                hwdata_q <= pend_data;
                dphase   <= 1'b1;
            end else begin
                dphase   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_ahb_wr.sv
// Directed testbench for dma_ahb_wr: FIFO model, bus monitor and cycle-exact checks.
module tb_dma_ahb_wr;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] dst_addr;
    logic [15:0] xfer_cnt;
    logic [1:0]  dst_size;
    logic        dst_incr;
    logic        busy;
    logic        done;
    logic        error;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        fifo_rd;

    dma_ahb_wr_if #(.DATA_WIDTH(32)) bus ();

    dma_ahb_wr #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .dst_addr   (dst_addr),
        .xfer_cnt   (xfer_cnt),
        .dst_size   (dst_size),
        .dst_incr   (dst_incr),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .ahb        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO model: bench pushes at negedge, DUT pops at posedge.
    logic [31:0] mem [256];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    logic        flush_req = 1'b0;
    logic        bad_pop = 1'b0;
    int          pop_cnt = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = mem[rd_ptr];

    always @(posedge clk) begin
        if (flush_req) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd) begin
            if (fifo_empty) begin
                bad_pop <= 1'b1;
            end else begin
                rd_ptr  <= rd_ptr + 8'd1;
                pop_cnt <= pop_cnt + 1;
            end
        end
    end

    // Bus monitor: logs every data phase completed with OKAY.
    logic        mon_pend = 1'b0;
    logic [31:0] mon_addr = 32'd0;
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    int          log_n = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mon_pend <= 1'b0;
        end else if (bus.HREADY) begin
            if (mon_pend && !bus.HRESP) begin
                log_addr[log_n] <= mon_addr;
                log_data[log_n] <= bus.HWDATA;
                log_n           <= log_n + 1;
            end
            mon_pend <= (bus.HTRANS == 2'b10);
            mon_addr <= bus.HADDR;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic fifo_push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    task automatic fifo_flush();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [15:0] cnt,
                                 input logic [1:0] sz, input logic inc);
        dst_addr = a;
        xfer_cnt = cnt;
        dst_size = sz;
        dst_incr = inc;
        start    = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p0;
        int l0;
        int b2b;
        int pushed;
        logic prev_ns;
        logic saw_done;

        resetn     = 1'b0;
        start      = 1'b0;
        dst_addr   = 32'd0;
        xfer_cnt   = 16'd0;
        dst_size   = 2'd0;
        dst_incr   = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_htrans", 32'(bus.HTRANS), 32'd0);
        checkOutput("rst_haddr",  bus.HADDR, 32'd0);
        checkOutput("rst_hwdata", bus.HWDATA, 32'd0);
        checkOutput("rst_busy",   32'(busy), 32'd0);
        checkOutput("rst_done",   32'(done), 32'd0);
        checkOutput("rst_error",  32'(error), 32'd0);
        checkOutput("rst_fiford", 32'(fifo_rd), 32'd0);
        checkOutput("const_hwrite", 32'(bus.HWRITE), 32'd1);
        checkOutput("const_hburst", 32'(bus.HBURST), 32'd0);
        checkOutput("const_hprot",  32'(bus.HPROT), 32'd3);
        resetn = 1'b1;
        @(negedge clk);

        // Basic 4-beat word write, zero wait
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) fifo_push(32'hA0A0_0000 + 32'(i));
        applyStimulus(32'h2000_0000, 16'd4, 2'd2, 1'b1);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput("t1_busy", 32'(busy), 32'(n < 7));
            checkOutput("t1_done", 32'(done), 32'(n == 7));
            checkOutput("t1_htrans", 32'(bus.HTRANS), (n >= 2 && n <= 5) ? 32'd2 : 32'd0);
            if (n >= 2 && n <= 5) checkOutput("t1_haddr", bus.HADDR, 32'h2000_0000 + 32'(4 * (n - 2)));
            if (n >= 3 && n <= 6) checkOutput("t1_hwdata", bus.HWDATA, 32'hA0A0_0000 + 32'(n - 3));
            if (n == 2) checkOutput("t1_hsize", 32'(bus.HSIZE), 32'd2);
        end
        checkOutput("t1_pops", 32'(pop_cnt - p0), 32'd4);

        // Wait states on beat 0
        p0 = pop_cnt;
        fifo_push(32'hB000_0000);
        fifo_push(32'hB000_0001);
        applyStimulus(32'h3000_0010, 16'd2, 2'd2, 1'b1);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput("t2_done", 32'(done), 32'(n == 7));
            if (n == 2) begin
                checkOutput("t2_htrans_b0", 32'(bus.HTRANS), 32'd2);
                checkOutput("t2_haddr_b0", bus.HADDR, 32'h3000_0010);
            end
            if (n >= 3 && n <= 5) begin
                checkOutput("t2_htrans_hold", 32'(bus.HTRANS), 32'd2);
                checkOutput("t2_haddr_hold", bus.HADDR, 32'h3000_0014);
                checkOutput("t2_hwdata_hold", bus.HWDATA, 32'hB000_0000);
            end
            if (n == 6) begin
                checkOutput("t2_htrans_end", 32'(bus.HTRANS), 32'd0);
                checkOutput("t2_hwdata_b1", bus.HWDATA, 32'hB000_0001);
            end
            if (n == 3 || n == 4) bus.HREADY = 1'b0;
            else bus.HREADY = 1'b1;
        end
        checkOutput("t2_pops", 32'(pop_cnt - p0), 32'd2);

        // FIFO starvation, fixed byte address
        p0 = pop_cnt;
        l0 = log_n;
        b2b = 0;
        pushed = 0;
        prev_ns = 1'b0;
        applyStimulus(32'h4000_0003, 16'd3, 2'd0, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 2) checkOutput("t3_hsize", 32'(bus.HSIZE), 32'd0);
            if (prev_ns && bus.HTRANS == 2'b10) b2b++;
            prev_ns = (bus.HTRANS == 2'b10);
            if (done) break;
            if ((n % 3) == 1 && pushed < 3) begin
                fifo_push(32'hC000_0000 + 32'(pushed));
                pushed++;
            end
        end
        checkOutput("t3_done", 32'(done), 32'd1);
        checkOutput("t3_gaps", 32'(b2b), 32'd0);
        checkOutput("t3_pops", 32'(pop_cnt - p0), 32'd3);
        checkOutput("t3_beats", 32'(log_n - l0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t3_addr", log_addr[l0 + i], 32'h4000_0003);
            checkOutput("t3_data", log_data[l0 + i], 32'hC000_0000 + 32'(i));
        end

        // ERROR response on beat 2 of 8
        p0 = pop_cnt;
        l0 = log_n;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) fifo_push(32'hD000_0000 + 32'(i));
        applyStimulus(32'h5000_0000, 16'd8, 2'd2, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) saw_done = 1'b1;
            if (n == 5) begin
                checkOutput("t4_haddr_b2_dphase", bus.HADDR, 32'h5000_000C);
                bus.HREADY = 1'b0;
                bus.HRESP  = 1'b1;
            end else if (n == 6) begin
                checkOutput("t4_cancel", 32'(bus.HTRANS), 32'd0);
                checkOutput("t4_busy_err", 32'(busy), 32'd1);
                checkOutput("t4_error_early", 32'(error), 32'd0);
                bus.HREADY = 1'b1;
                bus.HRESP  = 1'b1;
            end else if (n == 7) begin
                checkOutput("t4_error", 32'(error), 32'd1);
                checkOutput("t4_busy_fall", 32'(busy), 32'd0);
                bus.HRESP = 1'b0;
            end else if (n == 8) begin
                checkOutput("t4_error_pulse", 32'(error), 32'd0);
            end
        end
        checkOutput("t4_no_done", 32'(saw_done), 32'd0);
        checkOutput("t4_pops", 32'(pop_cnt - p0), 32'd4);
        checkOutput("t4_ok_beats", 32'(log_n - l0), 32'd2);
        checkOutput("t4_data1", log_data[l0 + 1], 32'hD000_0001);
        fifo_flush();

        // Zero count, then a start in the done cycle with an address wrap
        p0 = pop_cnt;
        applyStimulus(32'h1234_5678, 16'd0, 2'd2, 1'b1);
        @(negedge clk);
        start = 1'b0;
        checkOutput("t5_busy", 32'(busy), 32'd1);
        checkOutput("t5_htrans1", 32'(bus.HTRANS), 32'd0);
        @(negedge clk);
        checkOutput("t5_done", 32'(done), 32'd1);
        checkOutput("t5_busy_fall", 32'(busy), 32'd0);
        checkOutput("t5_htrans2", 32'(bus.HTRANS), 32'd0);
        checkOutput("t5_no_pop", 32'(pop_cnt - p0), 32'd0);
        fifo_push(32'hE000_0000);
        fifo_push(32'hE000_0001);
        applyStimulus(32'hFFFF_FFFC, 16'd2, 2'd3, 1'b1);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput("t5w_done", 32'(done), 32'(n == 5));
            if (n == 2) begin
                checkOutput("t5w_haddr0", bus.HADDR, 32'hFFFF_FFFC);
                checkOutput("t5w_hsize", 32'(bus.HSIZE), 32'd2);
            end
            if (n == 3) checkOutput("t5w_haddr1", bus.HADDR, 32'h0000_0000);
        end

        // Asynchronous reset during beat 1 of 4, then a clean transfer
        for (int i = 0; i < 4; i++) fifo_push(32'hF000_0000 + 32'(i));
        applyStimulus(32'h6000_0000, 16'd4, 2'd2, 1'b1);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("t6_beat1", bus.HADDR, 32'h6000_0004);
        resetn = 1'b0;
        #1;
        checkOutput("t6_rst_htrans", 32'(bus.HTRANS), 32'd0);
        checkOutput("t6_rst_haddr", bus.HADDR, 32'd0);
        checkOutput("t6_rst_hwdata", bus.HWDATA, 32'd0);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_fiford", 32'(fifo_rd), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        fifo_flush();
        l0 = log_n;
        fifo_push(32'h7777_0001);
        applyStimulus(32'h7000_0000, 16'd1, 2'd2, 1'b1);
        wait_done("t6_done", 20);
        checkOutput("t6_beats", 32'(log_n - l0), 32'd1);
        checkOutput("t6_addr", log_addr[l0], 32'h7000_0000);
        checkOutput("t6_data", log_data[l0], 32'h7777_0001);

        checkOutput("fifo_no_empty_pop", 32'(bad_pop), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
